// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters, per-pixel strobes for the
// image source, and sync/data-enable outputs delayed to match its BRAM read latency.
module vga_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] o_hcount,
  output logic [9:0] o_vcount,
  output logic       o_enable,
  output logic       o_newline,
  output logic       o_newframe,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de
);

  localparam int unsigned CW      = 10;
  localparam int unsigned XW      = CW + 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Window bounds carry one extra bit so an end bound of 1024 does not wrap.
  localparam logic [XW-1:0] H_ACT      = XW'(H_ACTIVE);
  localparam logic [XW-1:0] V_ACT      = XW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_START   = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_END     = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [XW-1:0] VS_START   = XW'(V_ACTIVE + V_FRONT);
  localparam logic [XW-1:0] VS_END     = XW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic          SYNC_IDLE  = ~SYNC_POL;

  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          newline_q;
  logic          newframe_q;

  // Stage 0 holds the undelayed decode of the current position; stage k is k cycles old.
  logic hs_pipe [0:PIPE_DELAY];
  logic vs_pipe [0:PIPE_DELAY];
  logic en_pipe [0:PIPE_DELAY];

  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic [XW-1:0] h_nxt_x;
  logic [XW-1:0] v_nxt_x;
  logic          en_nxt;
  logic          nl_nxt;
  logic          nf_nxt;
  logic          hs_nxt;
  logic          vs_nxt;

  // Next position and its decodes, so every output register describes the position it holds.
  always_comb begin
    h_nxt = hcount + CW'(1);
    v_nxt = vcount;
    if (hcount == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcount == V_LAST) ? '0 : vcount + CW'(1);
    end
    h_nxt_x = {1'b0, h_nxt};
    v_nxt_x = {1'b0, v_nxt};
    en_nxt  = (h_nxt_x < H_ACT) && (v_nxt_x < V_ACT);
    nl_nxt  = (h_nxt == H_LAST);
    nf_nxt  = nl_nxt && (v_nxt == V_LAST);
    hs_nxt  = ((h_nxt_x >= HS_START) && (h_nxt_x < HS_END)) ? SYNC_POL : SYNC_IDLE;
    vs_nxt  = ((v_nxt_x >= VS_START) && (v_nxt_x < VS_END)) ? SYNC_POL : SYNC_IDLE;
  end

  // Counters, strobes and the sync/enable delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount     <= H_LAST;
      vcount     <= V_LAST;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      for (int unsigned k = 0; k <= PIPE_DELAY; k++) begin
        hs_pipe[k] <= SYNC_IDLE;
        vs_pipe[k] <= SYNC_IDLE;
        en_pipe[k] <= 1'b0;
      end
    end else begin
      hcount     <= h_nxt;
      vcount     <= v_nxt;
      newline_q  <= nl_nxt;
      newframe_q <= nf_nxt;
      hs_pipe[0] <= hs_nxt;
      vs_pipe[0] <= vs_nxt;
      en_pipe[0] <= en_nxt;
      for (int unsigned k = 1; k <= PIPE_DELAY; k++) begin
        hs_pipe[k] <= hs_pipe[k-1];
        vs_pipe[k] <= vs_pipe[k-1];
        en_pipe[k] <= en_pipe[k-1];
      end
    end
  end

  assign o_hcount   = hcount;
  assign o_vcount   = vcount;
  assign o_enable   = en_pipe[0];
  assign o_newline  = newline_q;
  assign o_newframe = newframe_q;
  assign o_hsync    = hs_pipe[PIPE_DELAY];
  assign o_vsync    = vs_pipe[PIPE_DELAY];
  assign o_de       = en_pipe[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three modes checked cycle by cycle against an arithmetic
// raster model, plus per-frame totals and a modelled BRAM image source on the default mode.
module tb_vga_timing;

  localparam int NI = 3;
  localparam int unsigned HA [NI] = '{640, 64, 8};
  localparam int unsigned HF [NI] = '{16,  8,  2};
  localparam int unsigned HS [NI] = '{96,  16, 2};
  localparam int unsigned HB [NI] = '{48,  8,  2};
  localparam int unsigned VA [NI] = '{480, 48, 4};
  localparam int unsigned VF [NI] = '{10,  3,  1};
  localparam int unsigned VS [NI] = '{2,   2,  1};
  localparam int unsigned VB [NI] = '{33,  5,  1};
  localparam bit          POL[NI] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned PD [NI] = '{1,   2,  0};

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic en, nl, nf, hs, vs;
  } raw_t;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic en, nl, nf, hs, vs, de;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hc [NI];
  logic [9:0] vc [NI];
  logic       en [NI];
  logic       nl [NI];
  logic       nf [NI];
  logic       hs [NI];
  logic       vs [NI];
  logic       de [NI];

  always #5 clk = ~clk;

  vga_timing #(.H_ACTIVE(HA[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
               .V_ACTIVE(VA[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]),
               .SYNC_POL(POL[0]), .PIPE_DELAY(PD[0])) u_dflt (
    .clk(clk), .rst(rst), .o_hcount(hc[0]), .o_vcount(vc[0]), .o_enable(en[0]),
    .o_newline(nl[0]), .o_newframe(nf[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_de(de[0]));

  vga_timing #(.H_ACTIVE(HA[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
               .V_ACTIVE(VA[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
               .SYNC_POL(POL[1]), .PIPE_DELAY(PD[1])) u_mid (
    .clk(clk), .rst(rst), .o_hcount(hc[1]), .o_vcount(vc[1]), .o_enable(en[1]),
    .o_newline(nl[1]), .o_newframe(nf[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_de(de[1]));

  vga_timing #(.H_ACTIVE(HA[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
               .V_ACTIVE(VA[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]),
               .SYNC_POL(POL[2]), .PIPE_DELAY(PD[2])) u_small (
    .clk(clk), .rst(rst), .o_hcount(hc[2]), .o_vcount(vc[2]), .o_enable(en[2]),
    .o_newline(nl[2]), .o_newframe(nf[2]), .o_hsync(hs[2]), .o_vsync(vs[2]), .o_de(de[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int h_total(int i);
    return int'(HA[i] + HF[i] + HS[i] + HB[i]);
  endfunction

  function automatic int v_total(int i);
    return int'(VA[i] + VF[i] + VS[i] + VB[i]);
  endfunction

  // Position n cycles after reset release (n < 0: in reset), straight from the raster rules.
  function automatic raw_t ref_pos(int i, int n);
    raw_t r;
    int   ht, vt, h, v, hs0, vs0;
    ht  = h_total(i);
    vt  = v_total(i);
    hs0 = int'(HA[i] + HF[i]);
    vs0 = int'(VA[i] + VF[i]);
    if (n < 0) begin
      r.h  = 10'(ht - 1);
      r.v  = 10'(vt - 1);
      r.en = 1'b0;
      r.nl = 1'b0;
      r.nf = 1'b0;
      r.hs = ~POL[i];
      r.vs = ~POL[i];
    end else begin
      h    = n % ht;
      v    = (n / ht) % vt;
      r.h  = 10'(h);
      r.v  = 10'(v);
      r.en = (h < int'(HA[i])) && (v < int'(VA[i]));
      r.nl = (h == ht - 1);
      r.nf = (h == ht - 1) && (v == vt - 1);
      r.hs = (h >= hs0 && h < hs0 + int'(HS[i])) ? POL[i] : ~POL[i];
      r.vs = (v >= vs0 && v < vs0 + int'(VS[i])) ? POL[i] : ~POL[i];
    end
    return r;
  endfunction

  int   n [NI] = '{-1, -1, -1};
  raw_t hist [NI][$];

  // Model history, newest first; a reset wipes it so delayed outputs read as inactive.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      n[i] = rst ? -1 : n[i] + 1;
      if (rst) hist[i].delete();
      hist[i].push_front(ref_pos(i, n[i]));
      if (hist[i].size() > 8) void'(hist[i].pop_back());
    end
  end

  function automatic obs_t exp_obs(int i);
    raw_t c, d;
    obs_t o;
    c = hist[i][0];
    d = ref_pos(i, -1);
    if (hist[i].size() > int'(PD[i])) d = hist[i][PD[i]];
    o = {c.h, c.v, c.en, c.nl, c.nf, d.hs, d.vs, d.en};
    return o;
  endfunction

  function automatic obs_t dut_obs(int i);
    obs_t o;
    o = {hc[i], vc[i], en[i], nl[i], nf[i], hs[i], vs[i], de[i]};
    return o;
  endfunction

  // Image source consuming the strobes: zero at address 0, stripes elsewhere.
  function automatic logic [15:0] mem_word(int a);
    if (a == 0) return 16'h0000;
    return ((((a / 8) % 2) == 1) ? 16'hF0F0 : 16'h0F0F) ^ 16'(a);
  endfunction

  logic [19:0] src_addr;
  logic [15:0] pixel;

  always @(posedge clk) begin
    if (rst) begin
      src_addr <= '0;
      pixel    <= '0;
    end else begin
      if (nf[0])      src_addr <= '0;
      else if (en[0]) src_addr <= src_addr + 20'd1;
      if (en[0])      pixel    <= mem_word(int'(src_addr));
    end
  end

  bit mon_on = 1'b0;
  int f_cyc [NI];
  int f_en  [NI];
  int f_nl  [NI];
  int f_vs  [NI];
  int p, ph, pv;

  // Per-cycle comparison, per-frame totals and pixel alignment checks.
  always @(negedge clk) begin
    if (mon_on) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("pos%0d", i), 32'(dut_obs(i)), 32'(exp_obs(i)));
        if (n[i] < 0) begin
          f_cyc[i] = 0; f_en[i] = 0; f_nl[i] = 0; f_vs[i] = 0;
        end else begin
          f_cyc[i]++;
          f_en[i] += int'(en[i]);
          f_nl[i] += int'(nl[i]);
          f_vs[i] += int'(vs[i] == POL[i]);
          if (nf[i]) begin
            check($sformatf("nf_en%0d", i), 32'(en[i]), 32'(0));
            check($sformatf("f_cyc%0d", i), 32'(f_cyc[i]), 32'(h_total(i) * v_total(i)));
            check($sformatf("f_en%0d", i), 32'(f_en[i]), 32'(HA[i] * VA[i]));
            check($sformatf("f_nl%0d", i), 32'(f_nl[i]), 32'(v_total(i)));
            check($sformatf("f_vs%0d", i), 32'(f_vs[i]), 32'(int'(VS[i]) * h_total(i)));
            f_cyc[i] = 0; f_en[i] = 0; f_nl[i] = 0; f_vs[i] = 0;
          end
        end
      end
      if (n[0] >= 1) begin
        p  = n[0] - 1;
        ph = p % h_total(0);
        pv = (p / h_total(0)) % v_total(0);
        if (ph == 0 && pv == 0) check("pix_first", 32'(pixel), 32'(mem_word(0)));
        if (ph == 4 && pv == 2) check("pix_v2_h4", 32'(pixel), 32'(mem_word(2 * int'(HA[0]) + 4)));
      end
    end
  end

  bit found;
  int tgt_v;

  initial begin
    rst = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_h",  32'(hc[0]), 32'(799));
    check("rst_v",  32'(vc[0]), 32'(524));
    check("rst_en", 32'(en[0]), 32'(0));
    check("rst_hs", 32'(hs[0]), 32'(1));
    check("rst_vs", 32'(vs[0]), 32'(1));
    check("rst_de", 32'(de[0]), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rel_h",  32'(hc[0]), 32'(0));
    check("rel_v",  32'(vc[0]), 32'(0));
    check("rel_en", 32'(en[0]), 32'(1));
    check("rel_de", 32'(de[0]), 32'(0));
    @(negedge clk);
    check("rel_de1", 32'(de[0]), 32'(1));

    // Two full frames of the mid-size mode plus fourteen lines of the default mode.
    repeat (11400) @(negedge clk);

    tgt_v = int'(vc[0]) + 1;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (int'(hc[0]) == 300 && int'(vc[0]) == tgt_v) found = 1'b1;
    end
    check("wait_mid", 32'(found), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_h",  32'(hc[0]), 32'(799));
    check("mid_v",  32'(vc[0]), 32'(524));
    check("mid_en", 32'(en[0]), 32'(0));
    check("mid_hs", 32'(hs[0]), 32'(1));
    check("mid_vs", 32'(vs[0]), 32'(1));
    check("mid_de", 32'(de[0]), 32'(0));
    @(negedge clk);
    check("mid_h0", 32'(hc[0]), 32'(0));
    check("mid_v0", 32'(vc[0]), 32'(0));

    // Random reset pulses at random points in the raster.
    repeat (8) begin
      repeat ($urandom_range(30, 2500)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (700) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
